sa_result_serializer: RTL and testbench



---
 rtl/sa_result_serializer.sv | 169 ++++++++++++++++
 tb/tb_sa_result_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_serializer.sv
// Drain stage between the output FIFO array and the column UART: buffers 32-bit results
// in a word FIFO and issues them LSB byte first, one byte per transmitter completion.
//
// state | meaning
// IDLE  | waiting for a buffered word; pops the head when one is present
// SEND  | single cycle with o_tx_dv high for the current byte
// WAIT  | holding until the transmitter reports i_tx_done for that byte
module sa_result_serializer #(
    parameter int W_WORD = 32,
    parameter int W_BYTE = 8,
    parameter int W_ADDR = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_word_dv,
    input  logic [W_WORD-1:0] i_word,
    output logic              o_full,
    output logic              o_empty,
    input  logic              i_tx_done,
    output logic              o_tx_dv,
    output logic [W_BYTE-1:0] o_tx_byte,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [15:0]       o_words_sent
);

    localparam int              FIFO_DEPTH = 1 << W_ADDR;
    localparam int              N_BYTES    = W_WORD / W_BYTE;
    localparam logic [W_ADDR:0] DEPTH_CNT  = (W_ADDR + 1)'(FIFO_DEPTH);
    localparam logic [1:0]      LAST_IDX   = 2'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [W_WORD-1:0] mem_q [FIFO_DEPTH];
    logic [W_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [W_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [W_ADDR:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [W_WORD-1:0] shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic              tx_dv_q, tx_dv_d;
    logic [W_BYTE-1:0] tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic [15:0]       words_sent_q, words_sent_d;

    logic              full;
    logic              empty;
    logic              wr_en;
    logic              pop;
    logic [W_WORD-1:0] head_word;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    // Full is judged on the registered count, so a pop in the same cycle cannot rescue a write.
    assign wr_en     = i_word_dv & ~full;
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (i_word_dv & full);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        words_sent_d = words_sent_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = head_word;
                    idx_d     = '0;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = head_word[W_BYTE-1:0];
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (idx_q != LAST_IDX) begin
                        shift_d   = shift_q >> W_BYTE;
                        idx_d     = idx_q + 2'd1;
                        tx_dv_d   = 1'b1;
                        tx_byte_d = shift_q[2*W_BYTE-1:W_BYTE];
                        state_d   = SEND;
                    end else begin
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered, so they are derived from where the FSM is heading.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_word;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            shift_q      <= '0;
            idx_q        <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            busy_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign o_full       = full;
    assign o_empty      = empty;
    assign o_tx_dv      = tx_dv_q;
    assign o_tx_byte    = tx_byte_q;
    assign o_busy       = busy_q;
    assign o_overflow   = overflow_q;
    assign o_words_sent = words_sent_q;

endmodule

// File: tb/tb_sa_result_serializer.sv
// Directed bench for sa_result_serializer: byte order, strobe timing, FIFO full/overflow,
// spurious done pulses, asynchronous reset mid-word and word counter wrap.
module tb_sa_result_serializer;

    logic        i_clk;
    logic        i_rst;
    logic        i_word_dv;
    logic [31:0] i_word;
    logic        o_full;
    logic        o_empty;
    logic        i_tx_done;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        o_busy;
    logic        o_overflow;
    logic [15:0] o_words_sent;

    int          n_checks;
    int          n_fail;
    logic [7:0]  rx_q [$];
    logic [7:0]  b;

    sa_result_serializer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_word_dv    (i_word_dv),
        .i_word       (i_word),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .i_tx_done    (i_tx_done),
        .o_tx_dv      (o_tx_dv),
        .o_tx_byte    (o_tx_byte),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_words_sent (o_words_sent)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Every strobe seen mid-cycle is logged so no byte can slip past unnoticed.
    always @(negedge i_clk) begin
        if (i_rst === 1'b0 && o_tx_dv === 1'b1) begin
            rx_q.push_back(o_tx_byte);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        i_word_dv = 1'b0;
        i_tx_done = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic pulse_done(input int dly);
        repeat (dly) tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic get_byte(input string tag, output logic [7:0] rb);
        int n;
        n = 0;
        while (rx_q.size() == 0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_strobe_seen"}, 32'(rx_q.size() > 0), 1);
        if (rx_q.size() > 0) rb = rx_q.pop_front();
        else rb = 8'h00;
    endtask

    task automatic drain_word(input string tag, input logic [31:0] exp, input int dly);
        logic [7:0] rb;
        for (int i = 0; i < 4; i++) begin
            get_byte(tag, rb);
            check(tag, 32'(rb), 32'(exp[8*i +: 8]));
            pulse_done(dly);
        end
    endtask

    initial begin
        logic [31:0] exp_word;
        n_checks  = 0;
        n_fail    = 0;
        i_rst     = 1'b1;
        i_word_dv = 1'b0;
        i_word    = '0;
        i_tx_done = 1'b0;
        repeat (3) tick();

        check("rst_tx_dv",      32'(o_tx_dv), 0);
        check("rst_tx_byte",    32'(o_tx_byte), 0);
        check("rst_busy",       32'(o_busy), 0);
        check("rst_overflow",   32'(o_overflow), 0);
        check("rst_words_sent", 32'(o_words_sent), 0);
        check("rst_empty",      32'(o_empty), 1);
        check("rst_full",       32'(o_full), 0);
        i_rst = 1'b0;
        tick();

        // Single word, done answered 10 cycles after each strobe
        i_word    = 32'hDEADBEEF;
        i_word_dv = 1'b1;
        tick();
        i_word_dv = 1'b0;
        check("single_not_empty", 32'(o_empty), 0);
        check("single_no_early_strobe", 32'(o_tx_dv), 0);
        tick();
        check("single_strobe_2_edges", 32'(o_tx_dv), 1);
        check("single_first_byte_now", 32'(o_tx_byte), 32'hEF);
        check("single_busy", 32'(o_busy), 1);
        check("single_popped_empty", 32'(o_empty), 1);
        exp_word = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            get_byte("single_byte", b);
            check("single_byte", 32'(b), 32'(exp_word[8*i +: 8]));
            pulse_done(10);
            if (i < 3) check("single_gap_strobe", 32'(o_tx_dv), 1);
        end
        check("single_words_sent", 32'(o_words_sent), 1);
        check("single_idle", 32'(o_busy), 0);
        repeat (20) tick();
        check("single_no_extra_strobe", 32'(rx_q.size()), 0);

        // Back-to-back words
        do_reset();
        i_word    = 32'h03020100;
        i_word_dv = 1'b1;
        tick();
        i_word    = 32'h07060504;
        tick();
        i_word_dv = 1'b0;
        drain_word("b2b_w0", 32'h03020100, 3);
        tick();
        check("b2b_empty_after_2nd_pop", 32'(o_empty), 1);
        check("b2b_next_word_strobe", 32'(o_tx_dv), 1);
        drain_word("b2b_w1", 32'h07060504, 3);
        check("b2b_words_sent", 32'(o_words_sent), 2);

        // Overflow: 18 writes with the transmitter stalled
        do_reset();
        for (int k = 0; k < 18; k++) begin
            i_word    = 32'(k);
            i_word_dv = 1'b1;
            tick();
            if (k == 15) check("ovf_not_full_at_15", 32'(o_full), 0);
            if (k == 16) begin
                check("ovf_full_after_17th", 32'(o_full), 1);
                check("ovf_not_yet", 32'(o_overflow), 0);
            end
            if (k == 17) begin
                check("ovf_still_full", 32'(o_full), 1);
                check("ovf_set", 32'(o_overflow), 1);
            end
        end
        i_word_dv = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drain_word("ovf_word", 32'(k), 2);
        end
        repeat (30) tick();
        check("ovf_word17_never_sent", 32'(rx_q.size()), 0);
        check("ovf_words_sent", 32'(o_words_sent), 17);
        check("ovf_empty_end", 32'(o_empty), 1);
        check("ovf_sticky", 32'(o_overflow), 1);

        // Spurious done pulses in IDLE and SEND
        do_reset();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
        check("spur_idle_busy", 32'(o_busy), 0);
        check("spur_idle_no_strobe", 32'(rx_q.size()), 0);
        i_word    = 32'hA1B2C3D4;
        i_word_dv = 1'b1;
        tick();
        i_word_dv = 1'b0;
        tick();
        check("spur_send_cycle", 32'(o_tx_dv), 1);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("spur_send_no_advance", 32'(o_tx_dv), 0);
        repeat (5) tick();
        check("spur_one_strobe", 32'(rx_q.size()), 1);
        drain_word("spur_word", 32'hA1B2C3D4, 4);
        check("spur_words_sent", 32'(o_words_sent), 1);
        repeat (10) tick();
        check("spur_no_extra", 32'(rx_q.size()), 0);

        // Asynchronous reset in WAIT after the third byte, three words buffered
        do_reset();
        for (int k = 0; k < 4; k++) begin
            i_word    = 32'h0F0E0D0C + 32'(k);
            i_word_dv = 1'b1;
            tick();
        end
        i_word_dv = 1'b0;
        get_byte("rstmid_b0", b);
        check("rstmid_b0", 32'(b), 32'h0C);
        pulse_done(2);
        get_byte("rstmid_b1", b);
        check("rstmid_b1", 32'(b), 32'h0D);
        pulse_done(2);
        get_byte("rstmid_b2", b);
        check("rstmid_b2", 32'(b), 32'h0E);
        #2;
        i_rst = 1'b1;
        #1;
        check("rstmid_tx_dv", 32'(o_tx_dv), 0);
        check("rstmid_tx_byte", 32'(o_tx_byte), 0);
        check("rstmid_busy", 32'(o_busy), 0);
        check("rstmid_overflow", 32'(o_overflow), 0);
        check("rstmid_words_sent", 32'(o_words_sent), 0);
        check("rstmid_empty", 32'(o_empty), 1);
        check("rstmid_full", 32'(o_full), 0);
        tick();
        i_rst = 1'b0;
        rx_q.delete();
        repeat (10) tick();
        check("rstmid_silent", 32'(rx_q.size()), 0);
        check("rstmid_idle", 32'(o_busy), 0);
        i_word    = 32'h11223344;
        i_word_dv = 1'b1;
        tick();
        i_word_dv = 1'b0;
        drain_word("rstmid_new", 32'h11223344, 5);
        check("rstmid_words_sent_new", 32'(o_words_sent), 1);

        // Word counter wrap
        force dut.words_sent_q = 16'hFFFF;
        tick();
        tick();
        release dut.words_sent_q;
        tick();
        check("wrap_preload", 32'(o_words_sent), 32'hFFFF);
        i_word    = 32'h55667788;
        i_word_dv = 1'b1;
        tick();
        i_word_dv = 1'b0;
        drain_word("wrap_word", 32'h55667788, 2);
        check("wrap_zero", 32'(o_words_sent), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
